axi_read_arbiter: RTL and testbench

Shares one AXI4 read port (AR + R channels, INCR bursts) between NUM_PORTS read masters. Port 0 is the latency-critical video line fetcher and has fixed priority. Ports 1..NUM_PORTS-1 (CPU refill, DMA) are served round-robin. A grant limit keeps port 0 from starving them. Only one burst is outstanding at a time; the grant is held from AR acceptance until the R beat carrying last.

---
 rtl/axi_read_arbiter_if.sv | 42 ++++
 rtl/axi_read_arbiter.sv | 144 ++++++++++++++
 tb/tb_axi_read_arbiter.sv | 247 ++++++++++++++++++++++++
 3 files changed

// File: rtl/axi_read_arbiter_if.sv
// Bus bundle for axi_read_arbiter: per-requester AR/R signals (s_*) and the shared
// downstream AXI4 read port (m_*).
interface axi_read_arbiter_if #(
    parameter int NUM_PORTS = 3,
    parameter int ADDR_W    = 32,
    parameter int DATA_W    = 32
);
    logic [NUM_PORTS-1:0]        s_ar_valid;
    logic [NUM_PORTS-1:0]        s_ar_ready;
    logic [NUM_PORTS*ADDR_W-1:0] s_ar_addr;
    logic [NUM_PORTS*8-1:0]      s_ar_len;
    logic [NUM_PORTS-1:0]        s_r_valid;
    logic [NUM_PORTS-1:0]        s_r_ready;
    logic [DATA_W-1:0]           s_r_data;
    logic                        s_r_last;

    logic                        m_ar_valid;
    logic                        m_ar_ready;
    logic [ADDR_W-1:0]           m_ar_addr;
    logic [7:0]                  m_ar_len;
    logic [1:0]                  m_ar_burst;
    logic                        m_r_valid;
    logic                        m_r_ready;
    logic [DATA_W-1:0]           m_r_data;
    logic                        m_r_last;

    // Arbiter view.
    modport slave (
        input  s_ar_valid, s_ar_addr, s_ar_len, s_r_ready,
        input  m_ar_ready, m_r_valid, m_r_data, m_r_last,
        output s_ar_ready, s_r_valid, s_r_data, s_r_last,
        output m_ar_valid, m_ar_addr, m_ar_len, m_ar_burst, m_r_ready
    );

    // Requesters plus downstream memory.
    modport master (
        output s_ar_valid, s_ar_addr, s_ar_len, s_r_ready,
        output m_ar_ready, m_r_valid, m_r_data, m_r_last,
        input  s_ar_ready, s_r_valid, s_r_data, s_r_last,
        input  m_ar_valid, m_ar_addr, m_ar_len, m_ar_burst, m_r_ready
    );
endinterface

// File: rtl/axi_read_arbiter.sv
// Shares one AXI4 read port between NUM_PORTS masters: port 0 has bounded fixed priority,
// ports 1..NUM_PORTS-1 are round-robin. One burst outstanding at a time.
module axi_read_arbiter #(
    parameter int NUM_PORTS      = 3,
    parameter int ADDR_W         = 32,
    parameter int DATA_W         = 32,
    parameter int HP_GRANT_LIMIT = 4
) (
    input  logic              clk,
    input  logic              reset,
    axi_read_arbiter_if.slave bus
);
    localparam int GW  = $clog2(NUM_PORTS);
    localparam int HCW = $clog2(HP_GRANT_LIMIT + 1);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] ADDR = 2'd1;
    localparam logic [1:0] DATA = 2'd2;

    localparam logic [HCW-1:0] HP_LIMIT  = HCW'(HP_GRANT_LIMIT);
    localparam logic [GW-1:0]  LAST_PORT = GW'(NUM_PORTS - 1);

    logic [1:0]        r_state;
    logic [GW-1:0]     r_grant;
    logic [GW-1:0]     r_rr_ptr;
    logic [HCW-1:0]    r_hp_count;
    logic              r_ar_valid;
    logic [ADDR_W-1:0] r_ar_addr;
    logic [7:0]        r_ar_len;

    logic              w_lowpend;
    logic              w_any_valid;
    logic              w_hp_win;
    logic              w_low_found;
    logic [GW-1:0]     w_idx;
    logic [GW-1:0]     w_low_win;
    logic [GW-1:0]     w_win;
    logic [ADDR_W-1:0] w_sel_addr;
    logic [7:0]        w_sel_len;
    logic              w_r_done;

    assign w_lowpend   = |bus.s_ar_valid[NUM_PORTS-1:1];
    assign w_any_valid = |bus.s_ar_valid;
    assign w_hp_win    = bus.s_ar_valid[0] & (~w_lowpend | (r_hp_count < HP_LIMIT));

    // Search low ports starting after rr_ptr, wrapping within 1..NUM_PORTS-1.
    always_comb begin
        w_idx       = '0;
        w_low_win   = '0;
        w_low_found = 1'b0;
        for (int k = 1; k < NUM_PORTS; k++) begin
            w_idx = GW'(((int'(r_rr_ptr) - 1 + k) % (NUM_PORTS - 1)) + 1);
            if (!w_low_found && bus.s_ar_valid[w_idx]) begin
                w_low_found = 1'b1;
                w_low_win   = w_idx;
            end
        end
    end

    assign w_win = w_hp_win ? '0 : w_low_win;

    always_comb begin
        w_sel_addr = '0;
        w_sel_len  = '0;
        for (int i = 0; i < NUM_PORTS; i++) begin
            if (w_win == GW'(i)) begin
                w_sel_addr = bus.s_ar_addr[i*ADDR_W +: ADDR_W];
                w_sel_len  = bus.s_ar_len[i*8 +: 8];
            end
        end
    end

    always_comb begin
        bus.s_ar_ready = '0;
        if (r_state == IDLE && w_any_valid) begin
            bus.s_ar_ready[w_win] = 1'b1;
        end
    end

    always_comb begin
        bus.s_r_valid = '0;
        bus.m_r_ready = 1'b0;
        if (r_state == DATA) begin
            bus.s_r_valid[r_grant] = bus.m_r_valid;
            bus.m_r_ready          = bus.s_r_ready[r_grant];
        end
    end

    assign bus.s_r_data   = bus.m_r_data;
    assign bus.s_r_last   = bus.m_r_last;
    assign bus.m_ar_valid = r_ar_valid;
    assign bus.m_ar_addr  = r_ar_addr;
    assign bus.m_ar_len   = r_ar_len;
    assign bus.m_ar_burst = 2'd1;

    assign w_r_done = bus.m_r_valid & bus.m_r_ready & bus.m_r_last;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= IDLE;
            r_grant    <= '0;
            r_rr_ptr   <= LAST_PORT;
            r_hp_count <= '0;
            r_ar_valid <= 1'b0;
            r_ar_addr  <= '0;
            r_ar_len   <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_any_valid) begin
                        r_ar_addr  <= w_sel_addr;
                        r_ar_len   <= w_sel_len;
                        r_ar_valid <= 1'b1;
                        r_grant    <= w_win;
                        r_state    <= ADDR;
                        if (w_win == '0) begin
                            // Only consecutive port-0 wins against a waiting low port count.
                            if (!w_lowpend) begin
                                r_hp_count <= '0;
                            end else if (r_hp_count < HP_LIMIT) begin
                                r_hp_count <= r_hp_count + 1'b1;
                            end
                        end else begin
                            r_hp_count <= '0;
                            r_rr_ptr   <= w_win;
                        end
                    end
                end
                ADDR: begin
                    if (bus.m_ar_ready) begin
                        r_ar_valid <= 1'b0;
                        r_state    <= DATA;
                    end
                end
                DATA: begin
                    if (w_r_done) begin
                        r_state <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_axi_read_arbiter.sv
// Randomized bench for axi_read_arbiter: the bench plays requesters and downstream memory,
// and predicts every grant from a transaction-level model of the arbitration rules.
module tb_axi_read_arbiter;
    localparam int NP  = 3;
    localparam int AW  = 32;
    localparam int DW  = 32;
    localparam int LIM = 4;

    logic clk   = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    axi_read_arbiter_if #(.NUM_PORTS(NP), .ADDR_W(AW), .DATA_W(DW)) bus ();

    axi_read_arbiter #(
        .NUM_PORTS      (NP),
        .ADDR_W         (AW),
        .DATA_W         (DW),
        .HP_GRANT_LIMIT (LIM)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int n_checks = 0;
    int n_errors = 0;

    logic [NP-1:0] pend;
    logic [AW-1:0] req_addr [NP];
    logic [7:0]    req_len  [NP];
    int            m_hp;
    int            m_rr;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic int model_winner(input logic [NP-1:0] v);
        bit lowpend = (v >> 1) != '0;
        int p;
        if (v[0] && (!lowpend || m_hp < LIM)) return 0;
        for (int k = 1; k < NP; k++) begin
            p = m_rr + k;
            if (p >= NP) p -= NP - 1;
            if (v[p]) return p;
        end
        return 0;
    endfunction

    task automatic model_grant(input int w, input logic [NP-1:0] v);
        bit lowpend = (v >> 1) != '0;
        if (w == 0) begin
            if (lowpend) m_hp = (m_hp < LIM) ? m_hp + 1 : LIM;
            else         m_hp = 0;
        end else begin
            m_hp = 0;
            m_rr = w;
        end
    endtask

    task automatic new_req(input int i, input int len_fix);
        pend[i]     = 1'b1;
        req_addr[i] = $urandom;
        req_len[i]  = (len_fix >= 0) ? 8'(len_fix) : 8'($urandom_range(0, 7));
    endtask

    task automatic drive_reqs();
        bus.s_ar_valid = pend;
        for (int i = 0; i < NP; i++) begin
            bus.s_ar_addr[i*AW +: AW] = req_addr[i];
            bus.s_ar_len[i*8 +: 8]    = req_len[i];
        end
    endtask

    // Entered #1 after an edge with the DUT in its first IDLE cycle; returns likewise.
    task automatic do_txn(input logic [NP-1:0] force_mask, input logic [NP-1:0] rand_mask,
                          input int stall_fix, input int len_fix, input bit bp,
                          input int abort_at, output int obs);
        int            w;
        int            stall;
        int            beat;
        logic [AW-1:0] a;
        logic [7:0]    l;
        logic [DW-1:0] d;
        logic [NP-1:0] rdy;
        logic [NP-1:0] v;
        bit            mv;
        bit            fire;
        bit            tog;
        for (int i = 0; i < NP; i++) begin
            if (!pend[i] && (force_mask[i] || (rand_mask[i] && $urandom_range(0, 1) == 1)))
                new_req(i, len_fix);
        end
        if (pend == '0) new_req(NP - 1, len_fix);
        drive_reqs();
        bus.m_r_valid = 1'($urandom_range(0, 1));
        bus.m_r_last  = 1'b1;
        bus.s_r_ready = NP'($urandom);
        v = pend;
        w = model_winner(v);
        @(negedge clk);
        obs = -1;
        for (int i = 0; i < NP; i++) if (bus.s_ar_ready[i]) obs = i;
        check("ar_ready", bus.s_ar_ready, NP'(1) << w);
        check("idle_s_r_valid", bus.s_r_valid, '0);
        check("idle_m_r_ready", bus.m_r_ready, 1'b0);
        model_grant(w, v);
        a = req_addr[w];
        l = req_len[w];
        @(posedge clk); #1;
        pend[w] = 1'b0;
        drive_reqs();
        stall = (stall_fix >= 0) ? stall_fix : $urandom_range(0, 3);
        for (int c = 0; c <= stall; c++) begin
            bus.m_ar_ready = (c == stall);
            bus.m_r_valid  = 1'($urandom_range(0, 1));
            bus.s_r_ready  = NP'($urandom);
            @(negedge clk);
            check("m_ar_valid", bus.m_ar_valid, 1'b1);
            check("m_ar_addr", bus.m_ar_addr, a);
            check("m_ar_len", bus.m_ar_len, l);
            check("m_ar_burst", bus.m_ar_burst, 2'd1);
            check("addr_s_ar_ready", bus.s_ar_ready, '0);
            check("addr_m_r_ready", bus.m_r_ready, 1'b0);
            check("addr_s_r_valid", bus.s_r_valid, '0);
            @(posedge clk); #1;
        end
        bus.m_ar_ready = 1'b0;
        beat = 0;
        tog  = 1'b0;
        for (int cyc = 0; beat <= int'(l) && cyc < 200; cyc++) begin
            if (abort_at >= 0 && beat == abort_at) begin
                bus.m_r_valid = 1'b1;
                bus.m_r_last  = 1'b0;
                bus.s_r_ready = '1;
                reset = 1'b1;
                @(posedge clk); #1;
                reset = 1'b0;
                pend  = '0;
                drive_reqs();
                @(negedge clk);
                check("rst_s_r_valid", bus.s_r_valid, '0);
                check("rst_m_r_ready", bus.m_r_ready, 1'b0);
                check("rst_m_ar_valid", bus.m_ar_valid, 1'b0);
                check("rst_m_ar_addr", bus.m_ar_addr, '0);
                check("rst_s_ar_ready", bus.s_ar_ready, '0);
                m_hp = 0;
                m_rr = NP - 1;
                @(posedge clk); #1;
                bus.m_r_valid = 1'b0;
                bus.s_r_ready = '0;
                return;
            end
            mv  = bp ? 1'b1 : ($urandom_range(0, 3) != 0);
            rdy = NP'($urandom);
            if (bp) rdy[w] = tog;
            tog = ~tog;
            d   = DW'(a + AW'(beat));
            bus.m_r_valid = mv;
            bus.s_r_ready = rdy;
            bus.m_r_data  = d;
            bus.m_r_last  = (beat == int'(l));
            @(negedge clk);
            check("s_r_valid", bus.s_r_valid, mv ? (NP'(1) << w) : '0);
            check("m_r_ready", bus.m_r_ready, rdy[w]);
            check("s_r_data", bus.s_r_data, d);
            check("s_r_last", bus.s_r_last, (beat == int'(l)));
            check("data_m_ar_valid", bus.m_ar_valid, 1'b0);
            check("data_s_ar_ready", bus.s_ar_ready, '0);
            fire = mv && rdy[w];
            @(posedge clk); #1;
            if (fire) beat++;
        end
        if (beat <= int'(l)) check("burst_timeout", 64'(beat), 64'(l) + 1);
        bus.m_r_valid = 1'b0;
        bus.m_r_last  = 1'b0;
        bus.s_r_ready = '0;
    endtask

    int obs;
    int prio_exp [10] = '{0, 0, 0, 0, 1, 0, 0, 0, 0, 2};
    int rr_exp   [6]  = '{0, 1, 2, 1, 2, 1};

    initial begin
        pend = '0;
        for (int i = 0; i < NP; i++) begin
            req_addr[i] = '0;
            req_len[i]  = '0;
        end
        drive_reqs();
        bus.s_r_ready  = '0;
        bus.m_ar_ready = 1'b0;
        bus.m_r_valid  = 1'b0;
        bus.m_r_data   = '0;
        bus.m_r_last   = 1'b0;
        m_hp = 0;
        m_rr = NP - 1;

        repeat (2) @(posedge clk);
        @(negedge clk);
        check("reset_m_ar_valid", bus.m_ar_valid, 1'b0);
        check("reset_m_ar_addr", bus.m_ar_addr, '0);
        check("reset_m_ar_len", bus.m_ar_len, '0);
        check("reset_s_ar_ready", bus.s_ar_ready, '0);
        check("reset_s_r_valid", bus.s_r_valid, '0);
        check("reset_m_r_ready", bus.m_r_ready, 1'b0);
        @(posedge clk); #1;
        reset = 1'b0;

        // No valid, no grant.
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("novalid_s_ar_ready", bus.s_ar_ready, '0);
            check("novalid_m_ar_valid", bus.m_ar_valid, 1'b0);
            @(posedge clk); #1;
        end

        for (int i = 0; i < 10; i++) begin
            do_txn(3'b111, 3'b000, -1, -1, 1'b0, -1, obs);
            check("prio_order", 64'(obs), 64'(prio_exp[i]));
        end
        for (int i = 0; i < 6; i++) begin
            do_txn(3'b110, 3'b000, -1, -1, 1'b0, -1, obs);
            check("rr_order", 64'(obs), 64'(rr_exp[i]));
        end
        while (pend != '0) do_txn(3'b000, 3'b000, -1, -1, 1'b0, -1, obs);

        do_txn(3'b010, 3'b000, 0, 7, 1'b1, -1, obs);
        do_txn(3'b111, 3'b000, 10, -1, 1'b0, -1, obs);

        for (int i = 0; i < 50; i++)
            do_txn(3'b000, 3'b111, -1, -1, 1'($urandom_range(0, 1)), -1, obs);

        while (pend != '0) do_txn(3'b000, 3'b000, -1, -1, 1'b0, -1, obs);
        do_txn(3'b001, 3'b000, 1, 7, 1'b0, 2, obs);
        do_txn(3'b100, 3'b000, -1, -1, 1'b0, -1, obs);
        check("post_reset_grant", 64'(obs), 64'd2);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
